// File: rtl/vga_fetch_arbiter.sv
// rtl/vga_fetch_arbiter.sv - pixel RAM arbiter: line fetch into a double-buffered line buffer, host writes in the gaps
module vga_fetch_arbiter #(
    parameter int LINE_WORDS = 160,
    parameter int LINES      = 120,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    localparam int K_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
    localparam int LB_AW     = 1 + K_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [LB_AW-1:0]  lb_addr,
    output logic [DATA_W-1:0] lb_data,
    output logic              disp_bank,
    output logic              fetch_busy,
    output logic              overrun
);

    localparam int FL_W = $clog2(LINES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [K_W-1:0]    K_LAST  = K_W'(LINE_WORDS - 1);
    localparam logic [FL_W-1:0]   LINES_C = FL_W'(LINES);
    localparam logic [ADDR_W-1:0] LW_C    = ADDR_W'(LINE_WORDS);
    localparam logic [ADDR_W:0]   TOTAL_C = (ADDR_W + 1)'(LINES * LINE_WORDS);

    logic [1:0]        state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [FL_W-1:0]   fl_q, fl_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              fill_bank_q, fill_bank_d;
    logic              vpend_q, vpend_d;
    logic              overrun_q, overrun_d;
    logic              hblank_q, vblank_q;
    logic              rd_v_q;
    logic [K_W-1:0]    rd_k_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [LB_AW-1:0]  lb_addr_q;
    logic [DATA_W-1:0] lb_data_q;

    logic vtrig, htrig, trig, idle, rd_act, wr_fire, wr_hit;

    always_comb begin
        vtrig   = vblank & ~vblank_q;
        htrig   = hblank & ~hblank_q & ~vblank;
        trig    = vtrig | htrig;
        idle    = (state_q == S_IDLE);
        rd_act  = (state_q == S_FETCH);
        // Gated by reset so the host sees no handshake while reset is held.
        wr_ready = aresetn & idle & ~trig;
        wr_fire  = wr_valid & wr_ready;
        wr_hit   = wr_fire & ({1'b0, wr_addr} < TOTAL_C);
    end

    always_comb begin
        mem_en    = rd_act | wr_hit;
        mem_we    = wr_hit;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if (rd_act) begin
            mem_addr = base_q + ADDR_W'(k_q);
        end else if (wr_hit) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
        lb_we   = rd_v_q;
        lb_addr = rd_v_q ? {fill_bank_q, rd_k_q} : lb_addr_q;
        lb_data = rd_v_q ? mem_rdata : lb_data_q;
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        fl_d        = fl_q;
        base_d      = base_q;
        fill_bank_d = fill_bank_q;
        vpend_d     = vpend_q;
        overrun_d   = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    if (vtrig) begin
                        fl_d   = '0;
                        base_d = '0;
                    end
                    if (vtrig || (fl_q < LINES_C)) begin
                        state_d = S_FETCH;
                        k_d     = '0;
                    end
                end
            end
            S_FETCH: begin
                if (trig) overrun_d = 1'b1;
                // A frame start seen mid-fetch rewinds the line counter once this fetch retires.
                if (vtrig) vpend_d = 1'b1;
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (trig) overrun_d = 1'b1;
                state_d     = S_IDLE;
                fill_bank_d = ~fill_bank_q;
                vpend_d     = 1'b0;
                if (vpend_q || vtrig) begin
                    fl_d   = '0;
                    base_d = '0;
                end else begin
                    fl_d   = fl_q + 1'b1;
                    base_d = base_q + LW_C;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            fl_q        <= '0;
            base_q      <= '0;
            fill_bank_q <= 1'b0;
            vpend_q     <= 1'b0;
            overrun_q   <= 1'b0;
            hblank_q    <= 1'b1;
            vblank_q    <= 1'b1;
            rd_v_q      <= 1'b0;
            rd_k_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lb_addr_q   <= '0;
            lb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            fl_q        <= fl_d;
            base_q      <= base_d;
            fill_bank_q <= fill_bank_d;
            vpend_q     <= vpend_d;
            overrun_q   <= overrun_d;
            hblank_q    <= hblank;
            vblank_q    <= vblank;
            rd_v_q      <= rd_act;
            rd_k_q      <= k_q;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
            lb_addr_q   <= lb_addr;
            lb_data_q   <= lb_data;
        end
    end

    assign disp_bank  = ~fill_bank_q;
    assign fetch_busy = ~idle;
    assign overrun    = overrun_q;

endmodule

// File: doc/vga_fetch_arbiter.md
VGA_FETCH_ARBITER -- requirements
Module: vga_fetch_arbiter

Interface
REQ-001 Parameters SHALL be: LINE_WORDS, default 160, pixel words per fetched line; LINES, default 120, lines per frame; ADDR_W, default 15, memory address width; DATA_W, default 12, pixel word width (4:4:4 RGB).
REQ-002 aclk, input, 1: sole clock; all logic SHALL be rising-edge.
REQ-003 aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-004 hblank, vblank, inputs, 1 each: blanking flags from vga_interval, synchronous to aclk.
REQ-005 wr_valid, input, 1; wr_ready, output, 1; wr_addr, input, ADDR_W; wr_data, input, DATA_W: host write channel.
REQ-006 mem_en, mem_we, outputs, 1 each; mem_addr, output, ADDR_W; mem_wdata, output, DATA_W; mem_rdata, input, DATA_W: single-port pixel RAM with 1-cycle read latency.
REQ-007 lb_we, output, 1; lb_addr, output, 1+clog2(LINE_WORDS); lb_data, output, DATA_W: write port of the double-buffered line buffer. MSB of lb_addr is the bank.
REQ-008 disp_bank, output, 1: line-buffer bank the display reads. Always the complement of the fill bank.
REQ-009 fetch_busy, output, 1: high when state is not IDLE.
REQ-010 overrun, output, 1: sticky error flag.

Function
REQ-011 The block SHALL register hblank_q and vblank_q each cycle.
REQ-012 Triggers SHALL be defined as follows:
- vtrig = vblank & ~vblank_q.
- htrig = hblank & ~hblank_q & ~vblank.
- trig = vtrig | htrig.
REQ-013 On vtrig, line counter fl SHALL load 0 and row base SHALL load 0 before that fetch starts. Row base is an accumulator; no multiplier is used.
REQ-014 The FSM SHALL have three states, IDLE, FETCH and DRAIN, with these transitions:
- IDLE to FETCH on trig when fl < LINES (vtrig always qualifies).
- IDLE stays IDLE on trig when fl >= LINES.
- FETCH to DRAIN after issuing read index LINE_WORDS-1.
- DRAIN to IDLE unconditionally.
REQ-015 In FETCH cycle k (0..LINE_WORDS-1), the block SHALL drive mem_en=1, mem_we=0, mem_addr=base+k.
REQ-016 In cycle k+1, the block SHALL drive lb_we=1, lb_addr={fill_bank,k}, lb_data=mem_rdata. The last line-buffer write falls in DRAIN.
REQ-017 On leaving DRAIN, the block SHALL:
- toggle fill_bank (disp_bank follows);
- increment fl;
- add LINE_WORDS to base.
REQ-018 Total fetch occupancy SHALL be LINE_WORDS+1 cycles (161 by default), with the first read in the cycle after trig.
REQ-019 wr_ready SHALL be 1 only when state==IDLE and trig==0. The fetch trigger beats the host in the same cycle.
REQ-020 A write handshake (wr_valid & wr_ready) SHALL drive, in the same cycle, mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data. There is one write per cycle and no buffering.
REQ-021 A write with wr_addr >= LINES*LINE_WORDS SHALL still complete the handshake, but mem_en SHALL stay 0 (write dropped).
REQ-022 While wr_valid=1 and wr_ready=0, the host SHALL hold its payload; the block SHALL not sample it.
REQ-023 trig arriving while FETCH or DRAIN SHALL set overrun=1 and SHALL be ignored. The fetch in progress completes unchanged; overrun clears only by reset.
REQ-024 vtrig during an active fetch SHALL still reset fl and base for the next fetch, but the next fetch SHALL start only on a later trig.
REQ-025 When not fetching and not writing, mem_en, mem_we and lb_we SHALL be 0, and mem_addr, mem_wdata, lb_addr and lb_data SHALL hold their last values.

Reset
REQ-026 aresetn=0 SHALL immediately force:
- state=IDLE;
- fl=0, base=0, fill_bank=0 (so disp_bank=1);
- hblank_q=1, vblank_q=1;
- mem_en=0, mem_we=0, lb_we=0, wr_ready=0, fetch_busy=0, overrun=0.
REQ-027 Data/address outputs SHALL reset to 0.
REQ-028 Reset mid-fetch SHALL abort with no further memory or line-buffer writes.
REQ-029 The first trig after reset release SHALL require an observed 0-to-1 edge; a blank level already high at release SHALL not trigger.

Verification
REQ-030 Frame start: vblank 0->1 with RAM[i]=i -> first read in the next cycle at addr 0; lb writes of {0,k}=k for k=0..159; fetch_busy for 161 cycles; then disp_bank=0.
REQ-031 Line sequence: subsequent hblank rises (vblank=0) -> reads cover 160..319, then 320..479; bank alternates per line. After fl=120, further hblank rises cause no memory activity.
REQ-032 Host arbitration: wr_valid held during a fetch -> wr_ready=0 for all 161 cycles, then 1; a write at 0x0100 with data 0xABC lands as mem_we=1, addr 0x0100.
REQ-033 Same-cycle collision: wr_valid=1 in IDLE with hblank rising -> wr_ready=0 that cycle, FETCH entered, no host write issued.
REQ-034 Overrun: hblank pulses 100 cycles apart -> overrun=1 after the second edge; first fetch still writes all 160 words.
REQ-035 Reset mid-fetch: aresetn low at FETCH k=50 -> all enables 0 immediately; after release, no fetch until a fresh blank edge; out-of-range write 19200 handshakes with mem_en=0.
